// File: rtl/fetch_if.sv
// ---------------------------------------------------------------------------
// fetch_if
//   Bundles every signal between the fetch stage and its neighbours:
//   - hazard and redirect controls from the hazard unit and the ID stage;
//   - the instruction memory read path;
//   - the IF/ID pipeline register handed on to decode.
//   The slave modport is the fetch stage. The master modport is whatever
//   surrounds it: the pipeline, or a testbench.
//
//   stall           master->slave  hold PC and IF/ID this cycle
//   branch_taken    master->slave  redirect PC to branch_target
//   branch_target   master->slave  branch destination byte address
//   jump_en         master->slave  redirect PC to jump_target
//   jump_target     master->slave  jump destination byte address
//   imem_instr      master->slave  instruction word at the current pc
//   pc              slave->master  current PC / instruction memory address
//   if_id_instr     slave->master  registered instruction to decode
//   if_id_pc_plus2  slave->master  registered PC+2 of that instruction
//   if_id_valid     slave->master  1 = real instruction, 0 = bubble
//   fetch_count     slave->master  number of valid instructions captured
// ---------------------------------------------------------------------------
interface fetch_if;
  logic        stall;
  logic        branch_taken;
  logic [15:0] branch_target;
  logic        jump_en;
  logic [15:0] jump_target;
  logic [15:0] imem_instr;
  logic [15:0] pc;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic [15:0] fetch_count;

  modport master (
    output stall, branch_taken, branch_target, jump_en, jump_target, imem_instr,
    input  pc, if_id_instr, if_id_pc_plus2, if_id_valid, fetch_count
  );

  modport slave (
    input  stall, branch_taken, branch_target, jump_en, jump_target, imem_instr,
    output pc, if_id_instr, if_id_pc_plus2, if_id_valid, fetch_count
  );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage of the 16-bit MIPS pipeline.
//   - Owns the program counter and drives it as the instruction memory
//     address. Addresses are byte addresses and always halfword-aligned.
//   - Captures the instruction returned by memory into the IF/ID register.
//   - Holds the PC and IF/ID on a stall.
//   - Redirects on a jump or a taken branch, and flushes the wrong-path
//     instruction.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset
//     fif    fetch_if.slave. Carries the stall and redirect controls, the
//            imem read data, the pc, the IF/ID register and fetch_count.
//
//   Parameters:
//     RESET_PC   PC loaded on reset
//     NOP_INSTR  instruction injected into IF/ID on flush and on reset
// ---------------------------------------------------------------------------
module fetch_stage #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input logic   clk,
  input logic   rst_n,
  fetch_if.slave fif
);

  logic [15:0] pc_q,          pc_d;
  logic [15:0] instr_q,       instr_d;
  logic [15:0] pc_plus2_q,    pc_plus2_d;
  logic        valid_q,       valid_d;
  logic [15:0] fetch_count_q, fetch_count_d;

  logic [15:0] pc_inc;

  // Natural 16-bit wrap takes 16'hFFFE to 16'h0000.
  assign pc_inc = pc_q + 16'd2;

  always_comb begin
    // NOTE: every output of this block is given a default before any branch,
    // so no path leaves a signal unassigned and no latch is inferred.
    pc_d          = pc_q;
    instr_d       = instr_q;
    pc_plus2_d    = pc_plus2_q;
    valid_d       = valid_q;
    fetch_count_d = fetch_count_q;

    if (fif.jump_en || fif.branch_taken) begin
      // A jump outranks a branch. Either redirect beats a stall, because the
      // instruction being held is on the wrong path anyway.
      pc_d       = fif.jump_en ? {fif.jump_target[15:1], 1'b0}
                               : {fif.branch_target[15:1], 1'b0};
      instr_d    = NOP_INSTR;
      pc_plus2_d = 16'h0000;
      valid_d    = 1'b0;
    end else if (!fif.stall) begin
      pc_d          = pc_inc;
      instr_d       = fif.imem_instr;
      pc_plus2_d    = pc_inc;
      valid_d       = 1'b1;
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  // NOTE: state registers use non-blocking assignments only. All flops then
  // update together at the edge, whatever order the processes are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      instr_q       <= NOP_INSTR;
      pc_plus2_q    <= 16'h0000;
      valid_q       <= 1'b0;
      fetch_count_q <= 16'h0000;
    end else begin
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      pc_plus2_q    <= pc_plus2_d;
      valid_q       <= valid_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign fif.pc             = pc_q;
  assign fif.if_id_instr    = instr_q;
  assign fif.if_id_pc_plus2 = pc_plus2_q;
  assign fif.if_id_valid    = valid_q;
  assign fif.fetch_count    = fetch_count_q;

endmodule
